cic_decim_ctrl: RTL and testbench
=================================

# cic_decim_ctrl

Sequencer for one `cic_decim` instance. It generates the `strobe_in`/`strobe_out` pair from an ADC sample qualifier and owns the decimation `rate` register, so rate changes and enable transitions never leave the integrator/differentiator chain holding mixed-rate state. It also flags which decimator output samples are valid. It sits between the receive-path control registers and the CIC, one instance per decimator.

## Interface
- `N_STAGES`, 4: CIC order; sets the settling count.
- `MAX_RATE_LOG2`, 7: maximum legal rate is 2^MAX_RATE_LOG2.
- `DEFAULT_RATE`, 8: rate loaded at reset.
- `FLUSH_CYCLES`, 2: clocks for which `cic_reset` is held during a flush.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: channel run request.
- `sample_tick`, in, 1: one-clock pulse per input sample; tie high for a full-rate input.
- `rate_wr`, in, 1: one-clock write strobe for `rate_new`.
- `rate_new`, in, 8: requested decimation factor.
- `rate`, out, 8: active decimation factor, wired to the CIC `rate` input.
- `cic_reset`, out, 1: to the CIC `reset` input.
- `cic_enable`, out, 1: to the CIC `enable` input.
- `strobe_in`, out, 1: to the CIC `strobe_in` input.
- `strobe_out`, out, 1: to the CIC `strobe_out` input.
- `sample_valid`, out, 1: the CIC `signal_out` holds a valid sample this cycle.
- `rate_err`, out, 1: one-clock pulse when a rejected rate is written.
- `busy`, out, 1: high whenever the state is not RUN.

## Operation
- FSM states are IDLE, FLUSH and RUN. All outputs are registered.
- IDLE: `cic_enable`=0, strobes=0, `cic_reset`=0. When `enable`=1, go to FLUSH.
- FLUSH: `cic_reset`=1 for `FLUSH_CYCLES` clocks. Then go to RUN, with the decimation counter loaded to `rate`-1 and the settle counter loaded.
- RUN: `cic_enable`=1.
  - On each `sample_tick`, `strobe_in` pulses.
  - If the counter is 0 on that tick, `strobe_out` pulses in the same cycle and the counter reloads to `rate`-1. Otherwise the counter decrements.
  - `strobe_out` is only ever asserted together with `strobe_in`.
- Leaving RUN or FLUSH: when `enable`=0, go to IDLE on the next clock. Strobes are 0 from that clock onward and the CIC contents are left stale.
- Legal rates are 1 through 2^MAX_RATE_LOG2.
  - A legal `rate_wr` in any state updates `rate`. In RUN or FLUSH it also forces FLUSH, restarting the flush count.
  - An illegal write (0 or above max) pulses `rate_err`; `rate` and the state are unchanged.
- Rate 1 gives `strobe_out` on every `strobe_in`.
- The counter width is 8 bits. Because rates are checked at write time, it cannot wrap.
- `sample_valid` is `strobe_out` delayed by 2 clocks, matching the CIC pipeline-register update plus its output register. It is gated by the settle logic (see Configuration).
- Priority when events coincide: `reset` > `enable`=0 > legal `rate_wr` > `sample_tick`.
- `sample_tick` during FLUSH or IDLE is dropped.

## Timing
- Reset values: `rate`=DEFAULT_RATE, state IDLE, all other outputs 0.
- Reset mid-operation aborts immediately. The CIC is not flushed until the next IDLE→FLUSH transition.
- `enable` rising at edge k gives FLUSH at k+1; `cic_reset` is high for cycles k+1 through k+FLUSH_CYCLES; RUN starts at k+FLUSH_CYCLES+1.
- Strobe latency is 1 clock: `sample_tick` in cycle t produces `strobe_in` (and possibly `strobe_out`) in cycle t+1.
- The first `strobe_out` in RUN comes on the `rate`-th tick. Output spacing is exactly `rate` ticks.
- `strobe_out` in cycle t produces candidate `sample_valid` in cycle t+2.
- `rate_err` is asserted the cycle after the write.

## Configuration
- `CIC_CTRL_SETTLE_SKIP_EN` defined: after each entry to RUN, the first N_STAGES+1 `strobe_out` pulses do not produce `sample_valid`. These samples still fill the sampler and the differentiators. A flush or IDLE entry re-arms the skip.
- Undefined: every `strobe_out` produces `sample_valid`, and the settle counter logic is removed.

## Structure
- Shared package `cic_ctrl_pkg` holds:
  - the FSM state encoding (IDLE/FLUSH/RUN);
  - the rate legality function;
  - the `sample_valid` delay constant (2).
- One sub-module, `cic_rate_counter`: loadable down-counter with reload-on-zero. It takes tick, load and rate inputs and outputs a terminal pulse.
- The FSM, rate register and valid-delay logic live in the top module.

## Test plan
- Reset, then `enable`=1, rate 8, `sample_tick` tied high:
  - `cic_reset` is high for 2 cycles;
  - `strobe_out` comes every 8th cycle;
  - with the macro on, the first 5 outputs are not valid and `sample_valid` first rises 2 cycles after the 6th `strobe_out`.
- `sample_tick` every 3rd clock, rate 4: `strobe_out` spacing is 12 clocks and `strobe_in` spacing is 3 clocks.
- Write rate 0, then rate 200: `rate_err` pulses twice, `rate` stays 8, and there is no flush.
- Write rate 1 mid-RUN: a flush occurs, then `strobe_out` equals `strobe_in` every cycle.
- Drop `enable` the same cycle as a `rate_wr` of 16: the FSM goes to IDLE and `rate` becomes 16. A later `enable` flushes, and spacing is then 16.
- Assert `reset` mid-RUN: all outputs are 0 the next cycle and `rate`=8.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC decimator sequencer: FSM state encoding,
// rate legality check and the sample_valid delay that matches the CIC's
// internal pipeline.
package cic_ctrl_pkg;

  localparam int RATE_W      = 8;
  // The CIC updates its pipeline register on strobe_out, then its output
  // register one clock later.
  localparam int VALID_DELAY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } ctrl_state_t;

  // A rate is usable when it is non-zero and no larger than 2^max_log2.
  function automatic logic rate_legal(input logic [RATE_W-1:0] r, input int max_log2);
    logic [31:0] max_rate;
    max_rate = 32'd1 << max_log2;
    return (r != '0) && ({{(32-RATE_W){1'b0}}, r} <= max_rate);
  endfunction

endpackage

// File: rtl/cic_rate_counter.sv
// Decimation phase counter: loads rate-1 on entry to RUN, counts down one per
// accepted input tick and reloads when it reaches zero. terminal marks the tick
// that completes a decimation period.
module cic_rate_counter
  import cic_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic [RATE_W-1:0] rate,
  output logic              terminal
);

  logic [RATE_W-1:0] count;

  assign terminal = tick && (count == '0);

  // Down-counter with reload-on-zero; rates are validated upstream so rate-1
  // never underflows.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= rate - RATE_W'(1);
    end else if (tick) begin
      if (count == '0) begin
        count <= rate - RATE_W'(1);
      end else begin
        count <= count - RATE_W'(1);
      end
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencer for one cic_decim instance: owns the rate register, flushes the
// CIC on enable and on every accepted rate change, generates the
// strobe_in/strobe_out pair from sample_tick and flags valid output samples.
// Optional build macro: CIC_CTRL_SETTLE_SKIP_EN suppresses sample_valid for
// the first N_STAGES+1 outputs after each entry to RUN.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int N_STAGES      = 4,
  parameter int MAX_RATE_LOG2 = 7,
  parameter int DEFAULT_RATE  = 8,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_tick,
  input  logic              rate_wr,
  input  logic [RATE_W-1:0] rate_new,
  output logic [RATE_W-1:0] rate,
  output logic              cic_reset,
  output logic              cic_enable,
  output logic              strobe_in,
  output logic              strobe_out,
  output logic              sample_valid,
  output logic              rate_err,
  output logic              busy
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  // Reject parameter sets the sequencer cannot honour.
  if (N_STAGES < 1 || FLUSH_CYCLES < 1 || MAX_RATE_LOG2 < 0 || MAX_RATE_LOG2 > RATE_W - 1 ||
      DEFAULT_RATE < 1 || DEFAULT_RATE > (1 << MAX_RATE_LOG2)) begin : g_bad_param
    $error("cic_decim_ctrl: illegal parameter combination");
  end

  ctrl_state_t          state;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 wr_ok;
  logic                 run_tick;
  logic                 cnt_load;
  logic                 terminal;
  logic                 cand;
  logic [VALID_DELAY-1:0] vld_pipe;

  // enable=0 outranks a rate write, which in turn outranks a sample tick.
  assign wr_ok    = rate_wr && rate_legal(rate_new, MAX_RATE_LOG2);
  assign run_tick = (state == ST_RUN) && enable && !wr_ok && sample_tick;
  assign cnt_load = (state == ST_FLUSH) && enable && !wr_ok && (flush_cnt == FLUSH_LAST);

  cic_rate_counter u_rate_counter (
    .clock    (clock),
    .reset    (reset),
    .tick     (run_tick),
    .load     (cnt_load),
    .rate     (rate),
    .terminal (terminal)
  );

  // Control FSM and rate register; every output is driven from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      rate       <= RATE_W'(DEFAULT_RATE);
      cic_reset  <= 1'b0;
      cic_enable <= 1'b0;
      strobe_in  <= 1'b0;
      strobe_out <= 1'b0;
      rate_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rate_err   <= rate_wr && !wr_ok;
      strobe_in  <= 1'b0;
      strobe_out <= 1'b0;
      if (wr_ok) begin
        rate <= rate_new;
      end
      if (!enable) begin
        // CIC contents are left stale; the next enable flushes them.
        state      <= ST_IDLE;
        cic_reset  <= 1'b0;
        cic_enable <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_FLUSH;
            flush_cnt  <= '0;
            cic_reset  <= 1'b1;
            cic_enable <= 1'b0;
            busy       <= 1'b1;
          end
          ST_FLUSH: begin
            if (wr_ok) begin
              flush_cnt <= '0;
            end else if (flush_cnt == FLUSH_LAST) begin
              state      <= ST_RUN;
              cic_reset  <= 1'b0;
              cic_enable <= 1'b1;
              busy       <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
          end
          ST_RUN: begin
            if (wr_ok) begin
              state      <= ST_FLUSH;
              flush_cnt  <= '0;
              cic_reset  <= 1'b1;
              cic_enable <= 1'b0;
              busy       <= 1'b1;
            end else begin
              strobe_in  <= sample_tick;
              strobe_out <= terminal;
            end
          end
          default: begin
            state      <= ST_IDLE;
            cic_reset  <= 1'b0;
            cic_enable <= 1'b0;
            busy       <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef CIC_CTRL_SETTLE_SKIP_EN
  localparam int SETTLE_W = $clog2(N_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(N_STAGES + 1);

  logic [SETTLE_W-1:0] settle_cnt;

  assign cand = strobe_out && (settle_cnt == '0);

  // Counts off the outputs produced while the differentiators are still
  // filling; re-armed whenever the FSM is outside RUN.
  always_ff @(posedge clock) begin
    if (reset || (state != ST_RUN)) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (strobe_out && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SETTLE_W'(1);
    end
  end
`else
  assign cand = strobe_out;
`endif

  assign sample_valid = vld_pipe[VALID_DELAY-1];

  // Delay the valid candidate to line up with the CIC output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[VALID_DELAY-2:0], cand};
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: directed scenarios plus a random
// phase, every cycle compared against a transaction-level reference model.
module tb_cic_decim_ctrl;

  localparam int N_ST     = 4;
  localparam int FLUSH_N  = 2;
  localparam int MAX_RATE = 128;
  localparam int M_IDLE = 0, M_FLUSH = 1, M_RUN = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rate_wr = 1'b0;
  logic [7:0] rate_new = 8'd0;
  logic [7:0] rate;
  logic       cic_reset, cic_enable, strobe_in, strobe_out, sample_valid, rate_err, busy;

  cic_decim_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .rate_wr      (rate_wr),
    .rate_new     (rate_new),
    .rate         (rate),
    .cic_reset    (cic_reset),
    .cic_enable   (cic_enable),
    .strobe_in    (strobe_in),
    .strobe_out   (strobe_out),
    .sample_valid (sample_valid),
    .rate_err     (rate_err),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // reference model state
  int   m_mode = M_IDLE;
  int   m_left = 0;
  int   m_ticks = 0;
  int   m_outs = 0;
  logic m_cand = 1'b0;
  logic m_vmid = 1'b0;
  logic [7:0] e_rate = 8'd8;
  logic e_cr = 0, e_ce = 0, e_si = 0, e_so = 0, e_sv = 0, e_err = 0, e_busy = 0;

  // per-scenario observations
  int so_q[$];
  int si_q[$];
  int rst_hi, err_cnt, eq_mis, first_valid;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the applied inputs.
  task automatic model_step();
    logic legal;
    legal = (int'(rate_new) >= 1) && (int'(rate_new) <= MAX_RATE);
    if (reset) begin
      m_mode = M_IDLE; m_left = 0; m_ticks = 0; m_outs = 0;
      m_cand = 0; m_vmid = 0; e_rate = 8'd8;
      e_cr = 0; e_ce = 0; e_si = 0; e_so = 0; e_sv = 0; e_err = 0; e_busy = 0;
      return;
    end
    e_sv   = m_vmid;
    m_vmid = m_cand;
    m_cand = 0;
    e_err  = rate_wr && !legal;
    if (rate_wr && legal) e_rate = rate_new;
    e_si = 0;
    e_so = 0;
    if (!enable) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_FLUSH;
      m_left = FLUSH_N;
    end else if (m_mode == M_FLUSH) begin
      if (rate_wr && legal) begin
        m_left = FLUSH_N;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_RUN; m_ticks = 0; m_outs = 0;
        end
      end
    end else begin
      if (rate_wr && legal) begin
        m_mode = M_FLUSH;
        m_left = FLUSH_N;
      end else if (sample_tick) begin
        e_si = 1;
        m_ticks++;
        if (m_ticks % int'(e_rate) == 0) begin
          e_so = 1;
          m_outs++;
`ifdef CIC_CTRL_SETTLE_SKIP_EN
          m_cand = (m_outs > N_ST + 1);
`else
          m_cand = 1'b1;
`endif
        end
      end
    end
    e_cr   = (m_mode == M_FLUSH);
    e_ce   = (m_mode == M_RUN);
    e_busy = (m_mode != M_RUN);
  endtask

  // One clock: update model, sample DUT after the edge, compare and record.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    cyc_n++;
    chk("outputs", 32'({rate, cic_reset, cic_enable, strobe_in, strobe_out, sample_valid, rate_err, busy}),
        32'({e_rate, e_cr, e_ce, e_si, e_so, e_sv, e_err, e_busy}));
    if (strobe_out === 1'b1) so_q.push_back(cyc_n);
    if (strobe_in === 1'b1) si_q.push_back(cyc_n);
    if (cic_reset === 1'b1) rst_hi++;
    if (rate_err === 1'b1) err_cnt++;
    if (strobe_out !== strobe_in) eq_mis++;
    if (sample_valid === 1'b1 && first_valid < 0) first_valid = cyc_n;
  endtask

  task automatic clear_obs();
    so_q.delete(); si_q.delete();
    rst_hi = 0; err_cnt = 0; eq_mis = 0; first_valid = -1;
  endtask

  task automatic run_n(int n, int period);
    for (int i = 0; i < n; i++) begin
      sample_tick = (i % period) == 0;
      cyc();
    end
  endtask

  task automatic wr(logic [7:0] v);
    rate_wr = 1'b1;
    rate_new = v;
    cyc();
    rate_wr = 1'b0;
  endtask

  task automatic chk_gaps(string tag, input int q[$], int gap);
    chk({tag, "_count"}, 32'(q.size() >= 2), 32'd1);
    for (int i = 1; i < q.size(); i++) chk(tag, 32'(q[i] - q[i-1]), 32'(gap));
  endtask

  initial begin
    clear_obs();
    // reset state
    reset = 1'b1;
    cyc();
    cyc();
    chk("reset_rate", 32'(rate), 32'd8);
    chk("reset_outs", 32'({cic_reset, cic_enable, strobe_in, strobe_out, sample_valid, rate_err, busy}), 32'd0);
    reset = 1'b0;
    cyc();

    // enable at rate 8, full-rate ticks
    clear_obs();
    enable = 1'b1;
    run_n(72, 1);
    chk("flush_len", 32'(rst_hi), 32'(FLUSH_N));
    chk_gaps("so_gap_r8", so_q, 8);
`ifdef CIC_CTRL_SETTLE_SKIP_EN
    if (so_q.size() >= 6) chk("first_valid", 32'(first_valid), 32'(so_q[5] + 2));
    else chk("first_valid_outs", 32'(so_q.size()), 32'd6);
`else
    if (so_q.size() >= 1) chk("first_valid", 32'(first_valid), 32'(so_q[0] + 2));
    else chk("first_valid_outs", 32'(so_q.size()), 32'd1);
`endif

    // illegal rates: 0 and 200
    clear_obs();
    wr(8'd0);
    run_n(2, 1);
    wr(8'd200);
    run_n(3, 1);
    chk("err_pulses", 32'(err_cnt), 32'd2);
    chk("err_rate_kept", 32'(rate), 32'd8);
    chk("err_no_flush", 32'(rst_hi), 32'd0);

    // rate 4 with a tick every third clock
    wr(8'd4);
    clear_obs();
    run_n(110, 3);
    chk_gaps("so_gap_r4", so_q, 12);
    chk_gaps("si_gap_r4", si_q, 3);

    // rate 1 mid-run
    clear_obs();
    wr(8'd1);
    run_n(2, 1);
    chk("r1_flush", 32'(rst_hi), 32'(FLUSH_N));
    clear_obs();
    run_n(20, 1);
    chk("r1_so_eq_si", 32'(eq_mis), 32'd0);
    chk("r1_si_count", 32'(si_q.size()), 32'd20);

    // enable drop coinciding with a rate write of 16
    enable = 1'b0;
    wr(8'd16);
    chk("drop_busy", 32'(busy), 32'd1);
    chk("drop_rate", 32'(rate), 32'd16);
    chk("drop_cic_en", 32'(cic_enable), 32'd0);
    run_n(3, 1);
    enable = 1'b1;
    clear_obs();
    run_n(16 * 5 + 6, 1);
    chk("r16_flush", 32'(rst_hi), 32'(FLUSH_N));
    chk_gaps("so_gap_r16", so_q, 16);

    // reset mid-run
    reset = 1'b1;
    cyc();
    chk("midrst_outs", 32'({cic_reset, cic_enable, strobe_in, strobe_out, sample_valid, rate_err, busy}), 32'd0);
    chk("midrst_rate", 32'(rate), 32'd8);
    reset = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      reset       = ($urandom_range(0, 999) == 0);
      enable      = ($urandom_range(0, 119) != 0);
      sample_tick = ($urandom_range(0, 2) != 0);
      rate_wr     = ($urandom_range(0, 99) == 0);
      rate_new    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 10));
      cyc();
    end
    reset = 1'b0;
    rate_wr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
